// File: rtl/imem_load_controller.sv
// imem_load_controller
// Boot-time loader. It reads a big-endian byte stream made of a 16-bit word count N
// followed by N instruction words of two bytes each. Each pair of bytes becomes one
// 16-bit instruction written to instruction memory. The CPU is held in stall until
// the whole program has been loaded.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start              begins a load; honoured only in IDLE, DONE or ERROR
//   rx_data/valid/rdy  byte stream input; a byte transfers when rx_valid && rx_ready
//   instruction_in     assembled word to memory
//   load_address       memory write address
//   instruction_write  one-cycle write pulse per word
//   cpu_stall          low only in DONE
//   load_done          high in DONE
//   load_error         high in ERROR
//   words_loaded       number of words written in the current or last load
module imem_load_controller #(
  parameter int          MEM_DEPTH = 65536,
  parameter logic [15:0] BASE_ADDR = 16'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] instruction_in,
  output logic [15:0] load_address,
  output logic        instruction_write,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // The length check uses 17 bits so that MEM_DEPTH = 65536 can be represented.
  localparam logic [16:0] DEPTH17 = 17'(MEM_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] words_q, words_d;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] words_inc;

  assign rx_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
  assign xfer      = rx_valid && rx_ready;
  // Complete length as it will look once the LO byte is latched this cycle.
  assign len_full  = {len_q[15:8], rx_data};
  assign words_inc = words_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    words_d = words_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          words_d = 16'd0;
          addr_d  = BASE_ADDR;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          if (len_full == 16'd0)
            state_d = S_DONE;
          else if ({1'b0, len_full} > DEPTH17)
            state_d = S_ERROR;
          else
            state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          instr_d[15:8] = rx_data;
          state_d       = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          instr_d[7:0] = rx_data;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write pulse is visible for this whole cycle. The address and the
        // count advance on the edge that leaves WRITE.
        addr_d  = addr_q + 16'd1;
        words_d = words_inc;
        if (words_inc == len_q)
          state_d = S_DONE;
        else
          state_d = S_DATA_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      instr_q <= 16'd0;
      addr_q  <= BASE_ADDR;
      words_q <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  assign instruction_in    = instr_q;
  assign load_address      = addr_q;
  assign words_loaded      = words_q;
  assign instruction_write = (state_q == S_WRITE);
  assign cpu_stall         = (state_q != S_DONE);
  assign load_done         = (state_q == S_DONE);
  assign load_error        = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_load_controller.sv
// Testbench for imem_load_controller.
// It drives three instances with different parameters: the default configuration,
// a configuration whose base address wraps, and a configuration with a small memory.
// Expected writes are queued when each load is issued. A monitor pops and checks
// them whenever a DUT pulses instruction_write.
module tb_imem_load_controller;

  logic        clk;
  logic        rst      [3];
  logic        start    [3];
  logic [7:0]  rx_data  [3];
  logic        rx_valid [3];
  logic        rx_ready [3];
  logic [15:0] instr    [3];
  logic [15:0] addr     [3];
  logic        iw       [3];
  logic        stall    [3];
  logic        done     [3];
  logic        err      [3];
  logic [15:0] words    [3];

  logic [15:0] base_a  [3];
  int          depth_a [3];

  int tests = 0;
  int fails = 0;

  // Scoreboard of expected writes, in order: dut index, address, data.
  int          exp_dut  [$];
  logic [15:0] exp_addr [$];
  logic [15:0] exp_data [$];

  logic prev_iw [3];
  logic tog_s   [3];

  imem_load_controller #(.MEM_DEPTH(65536), .BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .instruction_in(instr[0]),
    .load_address(addr[0]), .instruction_write(iw[0]), .cpu_stall(stall[0]),
    .load_done(done[0]), .load_error(err[0]), .words_loaded(words[0]));

  imem_load_controller #(.MEM_DEPTH(65536), .BASE_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .instruction_in(instr[1]),
    .load_address(addr[1]), .instruction_write(iw[1]), .cpu_stall(stall[1]),
    .load_done(done[1]), .load_error(err[1]), .words_loaded(words[1]));

  imem_load_controller #(.MEM_DEPTH(4), .BASE_ADDR(16'h0000)) dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .rx_data(rx_data[2]),
    .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]), .instruction_in(instr[2]),
    .load_address(addr[2]), .instruction_write(iw[2]), .cpu_stall(stall[2]),
    .load_done(done[2]), .load_error(err[2]), .words_loaded(words[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each write pulse must match the front of the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (iw[d] === 1'b1) begin
        chk($sformatf("dut%0d write is single cycle", d), {31'd0, prev_iw[d]}, 32'd0);
        chk($sformatf("dut%0d rx_ready low in WRITE", d), {31'd0, rx_ready[d]}, 32'd0);
        if (exp_dut.size() == 0) begin
          chk($sformatf("dut%0d unexpected write", d), 32'd1, 32'd0);
        end else begin
          chk("write dut", d, exp_dut.pop_front());
          chk($sformatf("dut%0d write addr", d), {16'd0, addr[d]}, {16'd0, exp_addr.pop_front()});
          chk($sformatf("dut%0d write data", d), {16'd0, instr[d]}, {16'd0, exp_data.pop_front()});
        end
      end
      prev_iw[d] = (iw[d] === 1'b1);
    end
  end

  // Offers one byte, using gap mode 0 (always valid), 1 (toggle) or 2 (random).
  // While rx_valid is low, rx_data carries junk, which the DUT must ignore.
  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    logic v;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      case (gap)
        1:       begin tog_s[d] = ~tog_s[d]; v = tog_s[d]; end
        2:       v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      rx_valid[d] = v;
      rx_data[d]  = v ? b : 8'($urandom);
      if (v && rx_ready[d]) begin
        @(posedge clk);
        #1;
        rx_valid[d] = 1'b0;
        rx_data[d]  = 8'($urandom);
        return;
      end
    end
    chk($sformatf("dut%0d byte accept timeout", d), 32'd1, 32'd0);
    rx_valid[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Runs a complete load. The model derives N from the first two bytes, decides
  // between success and error, queues the expected writes and checks the final state.
  task automatic run_load(input int d, input logic [7:0] bs[$], input int gap, input bit start_mid);
    int          n;
    bit          is_err;
    logic [15:0] a;
    n      = {bs[0], bs[1]};
    is_err = (n > depth_a[d]);
    if (!is_err)
      for (int i = 0; i < n; i++) begin
        a = base_a[d] + 16'(i);
        exp_dut.push_back(d);
        exp_addr.push_back(a);
        exp_data.push_back({bs[2 + 2*i], bs[3 + 2*i]});
      end
    pulse_start(d);
    for (int i = 0; i < bs.size(); i++) begin
      if (i == 2 && start_mid) pulse_start(d);
      send_byte(d, bs[i], gap);
    end
    if (!is_err && n > 0) @(posedge clk);
    @(negedge clk);
    chk($sformatf("dut%0d load_done", d),  {31'd0, done[d]},  {31'd0, !is_err});
    chk($sformatf("dut%0d load_error", d), {31'd0, err[d]},   {31'd0, is_err});
    chk($sformatf("dut%0d cpu_stall", d),  {31'd0, stall[d]}, {31'd0, is_err});
    chk($sformatf("dut%0d words_loaded", d), {16'd0, words[d]}, is_err ? 32'd0 : 32'(16'(n)));
    a = is_err ? base_a[d] : base_a[d] + 16'(n);
    chk($sformatf("dut%0d final address", d), {16'd0, addr[d]}, {16'd0, a});
    chk($sformatf("dut%0d pending writes", d), exp_dut.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input int d);
    chk($sformatf("dut%0d rst rx_ready", d), {31'd0, rx_ready[d]}, 32'd0);
    chk($sformatf("dut%0d rst write", d),    {31'd0, iw[d]},       32'd0);
    chk($sformatf("dut%0d rst instr", d),    {16'd0, instr[d]},    32'd0);
    chk($sformatf("dut%0d rst addr", d),     {16'd0, addr[d]},     {16'd0, base_a[d]});
    chk($sformatf("dut%0d rst words", d),    {16'd0, words[d]},    32'd0);
    chk($sformatf("dut%0d rst stall", d),    {31'd0, stall[d]},    32'd1);
    chk($sformatf("dut%0d rst done", d),     {31'd0, done[d]},     32'd0);
    chk($sformatf("dut%0d rst error", d),    {31'd0, err[d]},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bs[$];
    int d, n, gap;
    base_a  = '{16'h0000, 16'hFFFF, 16'h0000};
    depth_a = '{65536, 65536, 4};
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; rx_valid[i] = 1'b0; rx_data[i] = 8'h00;
      prev_iw[i] = 1'b0; tog_s[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) chk_reset_vals(i);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Two words, rx_valid held high.
    bs = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_load(0, bs, 0, 0);
    // Zero length: DONE with no writes.
    bs = '{8'h00, 8'h00};
    run_load(0, bs, 0, 0);
    // Small memory: one word too many is an error, then a recovery load, then a full-depth load.
    bs = '{8'h00, 8'h05};
    run_load(2, bs, 0, 0);
    bs = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    run_load(2, bs, 0, 0);
    bs = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(2, bs, 2, 0);
    // Toggling rx_valid.
    bs = '{8'h00, 8'h01, 8'h55, 8'hAA};
    run_load(0, bs, 1, 0);
    // Wrapping base address, with a start pulse during DATA_HI that must be ignored.
    bs = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, bs, 0, 1);

    // Reset in the middle of the data: only the first word has landed.
    exp_dut.push_back(0); exp_addr.push_back(16'h0000); exp_data.push_back(16'h1122);
    pulse_start(0);
    bs = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < bs.size(); i++) send_byte(0, bs[i], 0);
    @(negedge clk);
    #2 rst[0] = 1'b1;
    #1 chk_reset_vals(0);
    chk("reset pending writes", exp_dut.size(), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;

    // Randomized loads across all three instances.
    for (int it = 0; it < 30; it++) begin
      d   = $urandom_range(0, 2);
      n   = (d == 2) ? $urandom_range(0, 6) : $urandom_range(0, 5);
      gap = $urandom_range(0, 2);
      bs = {};
      bs.push_back(8'(n >> 8));
      bs.push_back(8'(n));
      if (n <= depth_a[d])
        for (int i = 0; i < 2 * n; i++) bs.push_back(8'($urandom));
      run_load(d, bs, gap, (n > 0 && n <= depth_a[d]) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
